// File: rtl/ipu_frame_sequencer.sv
// Frame sequencer: preloads line buffers, issues one convolution per pixel to the
// coprocessor, extracts an 8-bit result and hands it to the VGA write path.
module ipu_frame_sequencer #(
  parameter int unsigned IMG_W        = 512,
  parameter int unsigned IMG_H        = 480,
  parameter int unsigned COORD_W      = 9,
  parameter int unsigned PIX_PER_WORD = 4,
  parameter logic [3:0]  OPCODE       = 4'b0111
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             start,
  input  logic [1:0]                                       size,
  input  logic [1:0]                                       op_mode,
  input  logic                                             abort,
  output logic                                             lb_load,
  output logic [COORD_W-1:0]                               lb_row,
  output logic [COORD_W+COORD_W-$clog2(PIX_PER_WORD)-1:0]  lb_addr,
  output logic                                             cp_req,
  output logic [31:0]                                      cp_inst,
  input  logic                                             cp_wait,
  input  logic                                             cp_done,
  input  logic [31:0]                                      cp_result,
  output logic                                             px_valid,
  output logic [7:0]                                       px_data,
  output logic [2*COORD_W-1:0]                             px_addr,
  input  logic                                             px_ready,
  output logic                                             busy,
  output logic                                             frame_done
);

  localparam int unsigned WC_W = COORD_W - $clog2(PIX_PER_WORD);
  localparam int unsigned WPR  = IMG_W / PIX_PER_WORD;

  localparam logic [WC_W-1:0]    WC_LAST  = WC_W'(WPR - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W:0]   ROW_END  = (COORD_W + 1)'(IMG_H);

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    ISSUE,
    WAIT_DONE,
    WRITE
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] row_q, col_q;
  logic [COORD_W:0]   load_row_q;
  logic [WC_W-1:0]    wc_q;
  logic [2:0]         rows_left_q;
  logic [1:0]         mode_q;

  logic               skip_row, row_loaded, last_col, last_row;
  logic [15:0]        abs_lo, abs_hi;
  logic [16:0]        mag_sum;
  logic [7:0]         result;

  // load_row carries one extra bit so rows past the frame bottom never wrap
  assign skip_row   = (load_row_q >= ROW_END);
  assign row_loaded = skip_row || (wc_q == WC_LAST);
  assign last_col   = (col_q == COL_LAST);
  assign last_row   = (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = PRELOAD;
      PRELOAD:   if (row_loaded && rows_left_q == 3'd1) state_d = ISSUE;
      ISSUE:     if (!cp_wait) state_d = WAIT_DONE;
      WAIT_DONE: if (cp_done) state_d = WRITE;
      WRITE: begin
        if (px_ready) begin
          if (!last_col)     state_d = ISSUE;
          else if (!last_row) state_d = PRELOAD;
          else               state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    abs_lo  = cp_result[15] ? (~cp_result[15:0] + 16'd1) : cp_result[15:0];
    abs_hi  = cp_result[31] ? (~cp_result[31:16] + 16'd1) : cp_result[31:16];
    mag_sum = {1'b0, abs_lo} + {1'b0, abs_hi};
    result  = '0;
    case (mode_q)
      2'd0: result = cp_result[7:0];
      2'd1: result = cp_result[23:16];
      2'd2: result = (|mag_sum[16:8]) ? 8'hFF : mag_sum[7:0];
      default: result = cp_result[7] ? 8'h00 : cp_result[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      load_row_q  <= '0;
      wc_q        <= '0;
      rows_left_q <= '0;
      mode_q      <= '0;
      px_data     <= '0;
      px_addr     <= '0;
      frame_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= 1'b0;
      if (!abort) begin
        case (state_q)
          IDLE: begin
            if (start) begin
              mode_q      <= op_mode;
              row_q       <= '0;
              col_q       <= '0;
              load_row_q  <= '0;
              wc_q        <= '0;
              rows_left_q <= {1'b0, size} + 3'd2;
            end
          end
          PRELOAD: begin
            if (row_loaded) begin
              wc_q        <= '0;
              load_row_q  <= load_row_q + 1'b1;
              rows_left_q <= rows_left_q - 3'd1;
            end else begin
              wc_q <= wc_q + 1'b1;
            end
          end
          WAIT_DONE: begin
            if (cp_done) begin
              px_data <= result;
              px_addr <= {row_q, col_q};
            end
          end
          WRITE: begin
            if (px_ready) begin
              if (!last_col) begin
                col_q <= col_q + 1'b1;
              end else if (!last_row) begin
                col_q       <= '0;
                row_q       <= row_q + 1'b1;
                rows_left_q <= 3'd1;
              end else begin
                frame_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign lb_load  = (state_q == PRELOAD) && !skip_row;
  assign lb_row   = load_row_q[COORD_W-1:0];
  assign lb_addr  = {lb_row, wc_q};
  assign cp_req   = (state_q == WAIT_DONE);
  assign px_valid = (state_q == WRITE);
  assign busy     = (state_q != IDLE);

  always_comb begin
    cp_inst = '0;
    if (cp_req) begin
      cp_inst[3:0]                  = OPCODE;
      cp_inst[4 +: COORD_W]         = col_q;
      cp_inst[4 + COORD_W +: COORD_W] = row_q;
    end
  end

endmodule

// File: doc/ipu_frame_sequencer.md
# ipu_frame_sequencer

Parametrised frame sequencer for the image-processing unit. It walks a full frame pixel by pixel and preloads the line buffers from video memory. For each output pixel it issues a convolution instruction to the coprocessor over a request/done handshake, extracts an 8-bit result according to a selectable mode, and delivers it to the VGA write path over a valid/ready handshake. It replaces the fixed 512x480, single-mode sequencer with generic geometry, kernel size, packing, abort and frame status.

## Interface

Parameters:
- IMG_W, 512: frame width in pixels; multiple of PIX_PER_WORD.
- IMG_H, 480: frame height in pixels.
- COORD_W, 9: coordinate width; 2^COORD_W >= max(IMG_W, IMG_H); 4+2*COORD_W <= 32.
- PIX_PER_WORD, 4: pixels per memory word; power of two.
- OPCODE, 4'b0111: opcode field placed in cp_inst[3:0].

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: frame start; sampled only in IDLE.
- size, in, 2: kernel code; kernel rows K = size+2 (2..5); latched at start.
- op_mode, in, 2: result extraction mode; latched at start.
- abort, in, 1: synchronous abort, any state.
- lb_load, out, 1: line-buffer load strobe; one memory word per cycle.
- lb_row, out, COORD_W: row being loaded.
- lb_addr, out, COORD_W+COORD_W-log2(PIX_PER_WORD): {lb_row, col/PIX_PER_WORD}.
- cp_req, out, 1: coprocessor request.
- cp_inst, out, 32: {zero pad, row, col, OPCODE}.
- cp_wait, in, 1: coprocessor busy.
- cp_done, in, 1: result valid, 1 cycle.
- cp_result, in, 32: coprocessor result.
- px_valid, out, 1: output pixel valid.
- px_data, out, 8: output pixel.
- px_addr, out, 2*COORD_W: {row, col} of px_data.
- px_ready, in, 1: sink accepts pixel.
- busy, out, 1: high in any state other than IDLE.
- frame_done, out, 1: 1-cycle pulse after the last pixel is accepted.

## Operation

- States: IDLE, PRELOAD, ISSUE, WAIT_DONE, WRITE.
- IDLE, with start=1: latch size and op_mode; row=col=0; rows_to_load=K; load_row=0; go to PRELOAD.
- PRELOAD:
  - Each cycle: lb_load=1, lb_row=load_row, word column wc increments by 1.
  - At wc = IMG_W/PIX_PER_WORD-1: wc=0, load_row+1, rows_to_load-1.
  - When rows_to_load reaches 0: go to ISSUE.
  - If load_row >= IMG_H, no strobe is issued; the row is skipped (counts as loaded).
- ISSUE:
  - If cp_wait=0: assert cp_req, drive cp_inst, go to WAIT_DONE.
  - Otherwise hold in ISSUE.
- WAIT_DONE:
  - cp_req and cp_inst held stable.
  - On cp_done: cp_req drops the same edge; capture the extracted result into px_data, row/col into px_addr; px_valid=1; go to WRITE.
- Result extraction:
  - op_mode 0: cp_result[7:0].
  - op_mode 1: cp_result[23:16].
  - op_mode 2: min(255, |cp_result[15:0]| + |cp_result[31:16]|), halves signed; 17-bit sum, then saturate.
  - op_mode 3: cp_result[7:0] with bit 7 set → 0 (clamp negative to 0).
- WRITE: hold px_valid, px_data and px_addr until px_ready=1. On acceptance:
  - col < IMG_W-1: col+1, go to ISSUE.
  - col = IMG_W-1, row < IMG_H-1: col=0, row+1, rows_to_load=1, go to PRELOAD.
  - last pixel (IMG_W-1, IMG_H-1): frame_done=1, go to IDLE.
- abort=1: next state IDLE; lb_load, cp_req, px_valid and busy deassert the next cycle; no frame_done. abort has priority over start and every handshake.
- start while busy is ignored.

## Timing

- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; counters 0.
- start to first lb_load: 1 cycle.
- Initial preload: K*IMG_W/PIX_PER_WORD cycles, minus skipped rows.
- Per-row reload: IMG_W/PIX_PER_WORD cycles.
- Per pixel, minimum 3 cycles: ISSUE(1) + WAIT_DONE(>=1) + WRITE(>=1).
  - cp_done in the first WAIT_DONE cycle yields px_valid on the next edge.
  - A cp_done seen while cp_req=0 is ignored.
- frame_done asserts on the edge after last-pixel acceptance; busy is low in the same cycle.
- Simultaneous start and abort in IDLE: abort wins; no frame starts.

## Test plan

- Reset: IMG_W=8, IMG_H=4, PIX_PER_WORD=4, size=1. Hold rst_n=0 with start=1 → all outputs 0, busy=0.
- Full frame, cp_done 1 cycle after cp_req, px_ready=1:
  - Preload strobes 6 words, rows 0,1,2.
  - 32 pixels in raster order; px_addr {0,0}..{3,7}.
  - Row reloads for rows 3,4(skipped),5(skipped); 1 frame_done.
- Backpressure: px_ready low 5 cycles at pixel {1,2} → px_data and px_addr stable, no new cp_req until accepted.
- Modes, cp_result=32'hFF80_0190:
  - op_mode 0 → 8'h90.
  - op_mode 1 → 8'h80.
  - op_mode 2 → |0x0190| + |-128| = 528 → 8'hFF.
  - op_mode 3 → 8'h00.
- cp_wait high 4 cycles in ISSUE → cp_req stays 0, then asserts; spurious cp_done before cp_req is ignored.
- abort during WAIT_DONE at pixel {2,5} → IDLE next cycle, no frame_done; a new start restarts from {0,0} with a full preload.
